present_key_schedule: RTL and testbench
=======================================

Name: present_key_schedule

Overview:
- Upstream stage of the PRESENT block cipher datapath: expands an 80-bit cipher key into the 32 64-bit round keys K1..K32.
- Stores all round keys in an internal register file so the cipher core can read them in forward order (encrypt) or reverse order (decrypt).
- Raises end_key_generation once all 32 round keys are valid; the cipher core starts block processing only after this flag is high.

Parameters:
- KEY_W, 80, cipher key width (128 when PRESENT_KEY128_EN is defined).
- RK_W, 64, round key width.
- NUM_RK, 32, number of round keys stored (K1..K32).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- key_load  input  1  single-cycle pulse; samples key and starts generation.
- key  input  KEY_W  cipher key, sampled only when key_load=1.
- rk_addr  input  5  round key read index; 0 selects K1, 31 selects K32.
- rk_o  output  64  round key at rk_addr, registered, 1-cycle read latency.
- busy  output  1  high while generation is in progress.
- end_key_generation  output  1  level; high once K1..K32 are valid.

Behaviour:
- Reset values: rk_o=0, busy=0, end_key_generation=0, FSM=IDLE, round counter=0. The register file is not reset.
- FSM states: IDLE, GEN, DONE.
  - IDLE -> GEN on key_load.
  - GEN -> DONE after K32 is written.
  - DONE -> GEN on key_load.
  - key_load in GEN restarts generation from the new key; the partial result is discarded.
- Load cycle: key_reg<=key, cnt<=1, busy<=1, end_key_generation<=0.
- Each GEN cycle, with counter value i (1..32):
  - rf[i-1] <= key_reg[79:16].
  - If i<32: key_reg <= update(key_reg, i).
  - cnt <= i+1.
- GEN lasts exactly 32 cycles. On the cycle after K32 is written: busy=0, end_key_generation=1.
- Latency: end_key_generation rises 33 cycles after the key_load edge.
- update(k, i), applied in this order:
  - Rotate left by 61: bit b moves to (b+61) mod 80.
  - Apply the PRESENT S-box to bits [79:76].
  - XOR bits [19:15] with i[4:0].
- rk_o <= rf[rk_addr] on every cycle, independent of state.
  - Reads during GEN return stale or partially updated contents.
  - The consumer must wait for end_key_generation.
- end_key_generation holds until the next key_load or rst.
- rst mid-GEN: return to IDLE, clear the flags, abandon generation.
- key_load and rst in the same cycle: rst wins.

Optional Feature:
- Macro: PRESENT_KEY128_EN.
- Defined:
  - KEY_W=128.
  - Round key = key_reg[127:64].
  - update rotates left by 61 mod 128.
  - S-box is applied to both [127:124] and [123:120].
  - i is XORed into [66:62].
- Not defined: 80-bit behaviour exactly as described above.
- Port list, timing and the 33-cycle latency are identical in both modes.

Decomposition:
- Shared package present_pkg holds:
  - The 16-entry PRESENT S-box constant and a sbox4 function.
  - KEY_W, RK_W and NUM_RK localparams, selected by the macro.
  - The FSM state enum typedef.
- One sub-module, present_rk_regfile: 32x64, one write port, registered read port.

Test Plan:
- rst, then key_load with key=0 -> busy for 32 cycles, end_key_generation=1 at cycle 33. Read addr 0 -> 0x0000000000000000; addr 1 -> 0xC000000000000000; addr 2 -> 0x5000180000000001.
- key=0xFFFF_FFFF_FFFF_FFFF_FFFF, read all 32 addresses -> every value matches the golden model. Encrypting plaintext 0 with the attached present core gives 0xE72C46C0F5945049.
- key_load asserted again at GEN cycle 10 with key=0 -> generation restarts; end_key_generation rises 33 cycles after the second load; contents match the key=0 vectors.
- rst asserted at GEN cycle 20 -> next cycle busy=0, end_key_generation=0, rk_o=0; a following key_load completes normally.
- Back-to-back reads of addr 31 down to 0 in DONE -> each rk_o appears exactly 1 cycle after its address.
- PRESENT_KEY128_EN build, key=0 -> K1=0. End-to-end encryption of plaintext 0 matches the PRESENT-128 reference ciphertext 0x96DB702A2E6900AF.

Source files
------------

// File: rtl/present_pkg.sv
// ============================================================================
// Module   : present_pkg
// Purpose  : Shared PRESENT key-schedule constants, S-box, state enum and the
//            key register update. Build macro: PRESENT_KEY128_EN (128-bit key).
// Revision : 1.0
// ============================================================================
`default_nettype none

package present_pkg;

`ifdef PRESENT_KEY128_EN
    localparam int KEY_W    = 128;
    localparam int c_RC_LSB = 62;
`else
    localparam int KEY_W    = 80;
    localparam int c_RC_LSB = 15;
`endif
    localparam int RK_W   = 64;
    localparam int NUM_RK = 32;

    // Nibble x of this constant holds S(x).
    localparam logic [63:0] c_SBOX = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return c_SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                    input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        // Left rotation by 61 expressed as a concatenation.
        r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
        r[KEY_W-1 -: 4] = sbox4(r[KEY_W-1 -: 4]);
`ifdef PRESENT_KEY128_EN
        r[KEY_W-5 -: 4] = sbox4(r[KEY_W-5 -: 4]);
`endif
        r[c_RC_LSB +: 5] = r[c_RC_LSB +: 5] ^ rc;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/present_key_schedule_if.sv
// ============================================================================
// Module   : present_key_schedule_if
// Purpose  : Key-load / round-key read bus between cipher core and key
//            schedule. Key width follows PRESENT_KEY128_EN via present_pkg.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface present_key_schedule_if;
    import present_pkg::*;

    logic             key_load;
    logic [KEY_W-1:0] key;
    logic [4:0]       rk_addr;
    logic [RK_W-1:0]  rk_o;
    logic             busy;
    logic             end_key_generation;

    modport master (
        output key_load, key, rk_addr,
        input  rk_o, busy, end_key_generation
    );

    modport slave (
        input  key_load, key, rk_addr,
        output rk_o, busy, end_key_generation
    );
endinterface

`default_nettype wire

// File: rtl/present_rk_regfile.sv
// ============================================================================
// Module   : present_rk_regfile
// Purpose  : 32 x 64 round-key storage, one write port, registered read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module present_rk_regfile
    import present_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_we,
    input  wire logic [4:0]      i_waddr,
    input  wire logic [RK_W-1:0] i_wdata,
    input  wire logic [4:0]      i_raddr,
    output logic      [RK_W-1:0] o_rdata
);

    logic [RK_W-1:0] r_rf [NUM_RK];
    logic [RK_W-1:0] r_rdata;

    // Storage array carries no reset so it maps onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_rf[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_rf[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/present_key_schedule.sv
// ============================================================================
// Module   : present_key_schedule
// Purpose  : Expands the cipher key into round keys K1..K32 and serves them
//            by index. Build macro: PRESENT_KEY128_EN selects 128-bit keys.
// Revision : 1.0
// ============================================================================
`default_nettype none

module present_key_schedule
    import present_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    present_key_schedule_if.slave bus
);

    state_t           r_state;
    logic [KEY_W-1:0] r_key;
    logic [5:0]       r_cnt;
    logic             r_busy;
    logic             r_end;

    logic             w_we;
    logic [4:0]       w_waddr;
    logic [RK_W-1:0]  w_rk;

    assign w_we    = (r_state == ST_GEN);
    // Counter value i writes entry i-1; i=32 wraps cleanly to 31 in 5 bits.
    assign w_waddr = r_cnt[4:0] - 5'd1;
    assign w_rk    = r_key[KEY_W-1 -: RK_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b0;
            r_end   <= 1'b0;
        end else if (bus.key_load) begin
            r_state <= ST_GEN;
            r_key   <= bus.key;
            r_cnt   <= 6'd1;
            r_busy  <= 1'b1;
            r_end   <= 1'b0;
        end else begin
            case (r_state)
                ST_GEN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd32) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_end   <= 1'b1;
                    end else begin
                        r_key <= key_update(r_key, r_cnt[4:0]);
                    end
                end
                ST_IDLE, ST_DONE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_end   <= 1'b0;
                end
            endcase
        end
    end

    present_rk_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_rk),
        .i_raddr (bus.rk_addr),
        .o_rdata (bus.rk_o)
    );

    assign bus.busy               = r_busy;
    assign bus.end_key_generation = r_end;

endmodule

`default_nettype wire

// File: tb/tb_present_key_schedule.sv
// ============================================================================
// Module   : tb_present_key_schedule
// Purpose  : Scoreboard bench for present_key_schedule; round keys read back
//            are also run through a PRESENT encryption against known vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_present_key_schedule;
    import present_pkg::*;

    typedef struct {
        bit          capture;
        logic [4:0]  addr;
        logic [63:0] exp;
        string       name;
    } rd_t;

`ifdef PRESENT_KEY128_EN
    localparam logic [63:0] c_CT_ZERO = 64'h96DB702A2E6900AF;
`else
    localparam logic [63:0] c_CT_ZERO = 64'h5579C1387B228445;
    localparam logic [63:0] c_CT_ONES = 64'hE72C46C0F5945049;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    present_key_schedule_if bus ();

    present_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    rd_t         sb_q[$];
    rd_t         mon_e;
    logic [63:0] cap [32];
    logic        rd_issue = 1'b0;
    logic        rd_v     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read data appears one cycle after the address is presented.
    always @(posedge clk) rd_v <= rd_issue;

    always @(negedge clk) begin
        if (rd_v) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.capture) cap[mon_e.addr] = bus.rk_o;
                else chk(mon_e.name, bus.rk_o, mon_e.exp);
            end
        end
    end

    function automatic logic [3:0] ref_s(input logic [3:0] x);
        case (x)
            4'h0: ref_s = 4'hC;  4'h1: ref_s = 4'h5;  4'h2: ref_s = 4'h6;  4'h3: ref_s = 4'hB;
            4'h4: ref_s = 4'h9;  4'h5: ref_s = 4'h0;  4'h6: ref_s = 4'hA;  4'h7: ref_s = 4'hD;
            4'h8: ref_s = 4'h3;  4'h9: ref_s = 4'hE;  4'hA: ref_s = 4'hF;  4'hB: ref_s = 4'h8;
            4'hC: ref_s = 4'h4;  4'hD: ref_s = 4'h7;  4'hE: ref_s = 4'h1;  default: ref_s = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [63:0] s, t;
        s = pt;
        for (int r = 0; r < 31; r++) begin
            s = s ^ cap[r];
            for (int n = 0; n < 16; n++) s[n*4 +: 4] = ref_s(s[n*4 +: 4]);
            for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : ((b * 16) % 63)] = s[b];
            s = t;
        end
        return s ^ cap[31];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [KEY_W-1:0] k);
        bus.key      = k;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (bus.busy && c < 100) begin
            c++;
            tick();
        end
        chk({name, "_busy_cycles"}, 64'(c), 64'd32);
        chk({name, "_end"}, 64'(bus.end_key_generation), 64'd1);
    endtask

    task automatic rd(input logic [4:0] a, input bit capture, input logic [63:0] exp,
                      input string name);
        bus.rk_addr = a;
        rd_issue    = 1'b1;
        sb_q.push_back('{capture, a, exp, name});
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic drain();
        tick();
        tick();
    endtask

    // Back-to-back descending reads, then encrypt plaintext 0 with the keys.
    task automatic burst_enc(input string name, input logic [63:0] exp_ct);
        for (int a = 31; a >= 0; a--) rd(5'(a), 1'b1, 64'd0, "cap");
        drain();
        chk(name, encrypt(64'd0), exp_ct);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.key_load = 1'b0;
        bus.key      = '0;
        bus.rk_addr  = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rk_o", bus.rk_o, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_end",  64'(bus.end_key_generation), 64'd0);

        // Key zero: latency, first round keys, descending burst.
        load('0);
        chk("zero_busy_c1", 64'(bus.busy), 64'd1);
        wait_done("zero");
        rd(5'd0, 1'b0, 64'h0000000000000000, "zero_K1");
`ifndef PRESENT_KEY128_EN
        rd(5'd1, 1'b0, 64'hC000000000000000, "zero_K2");
        rd(5'd2, 1'b0, 64'h5000180000000001, "zero_K3");
`endif
        drain();
        burst_enc("zero_enc", c_CT_ZERO);
        tick();
        tick();
        chk("zero_end_hold", 64'(bus.end_key_generation), 64'd1);

`ifndef PRESENT_KEY128_EN
        load('1);
        wait_done("ones");
        burst_enc("ones_enc", c_CT_ONES);
`endif

        // Reload at GEN cycle 10 restarts from the new key.
        load('1);
        repeat (9) tick();
        load('0);
        chk("rl_end_low", 64'(bus.end_key_generation), 64'd0);
        wait_done("rl");
        rd(5'd0, 1'b0, 64'h0000000000000000, "rl_K1");
`ifndef PRESENT_KEY128_EN
        rd(5'd1, 1'b0, 64'hC000000000000000, "rl_K2");
`endif
        drain();
        burst_enc("rl_enc", c_CT_ZERO);

        // Reset at GEN cycle 20 abandons generation.
        load('1);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", 64'(bus.busy), 64'd0);
        chk("mr_end",  64'(bus.end_key_generation), 64'd0);
        chk("mr_rk_o", bus.rk_o, 64'd0);
        load('0);
        wait_done("mr");
`ifndef PRESENT_KEY128_EN
        rd(5'd2, 1'b0, 64'h5000180000000001, "mr_K3");
`else
        rd(5'd0, 1'b0, 64'h0000000000000000, "mr_K1");
`endif
        drain();
        burst_enc("mr_enc", c_CT_ZERO);

        chk("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
